// File: rtl/addsub_accum.sv
// Packet accumulator behind the 36-bit add/sub datapath: sums per-beat a+b / a-b
// over a packet and hands off total, beat count and sticky signed overflow.
// Optional clamp-on-overflow arithmetic is enabled by defining ADDSUB_ACCUM_SAT_EN.
//
// state  | meaning
// S_IDLE | no packet in progress, accumulator empty
// S_ACC  | packet in progress, acc/cnt/ovf hold partial result
// S_OUT  | packet result held on out_*, waiting for out_ready
module addsub_accum #(
    parameter int WIDTH = 36,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_add,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [WIDTH-1:0] r_out_sum;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_ovf;

    logic             w_accept;
    logic [WIDTH-1:0] w_b_op;
    logic [WIDTH-1:0] w_r_wrap;
    logic [WIDTH-1:0] w_r;
    logic             w_op_ovf;
    logic [WIDTH-1:0] w_nacc_raw;
    logic             w_acc_ovf;
    logic             w_beat_ovf;
    logic [WIDTH-1:0] w_nacc;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Subtraction as a + ~b + 1 shares one adder with addition.
    assign w_b_op   = in_add ? in_b : ~in_b;
    assign w_r_wrap = in_a + w_b_op + {{(WIDTH-1){1'b0}}, ~in_add};
    assign w_op_ovf = (in_a[WIDTH-1] == w_b_op[WIDTH-1]) && (w_r_wrap[WIDTH-1] != in_a[WIDTH-1]);

`ifdef ADDSUB_ACCUM_SAT_EN
    logic [WIDTH+1:0] w_b_ext;
    logic [WIDTH+1:0] w_total;

    // An overflowing beat's true result always carries the sign of a.
    assign w_r     = w_op_ovf ? (in_a[WIDTH-1] ? SMIN : SMAX) : w_r_wrap;
    assign w_b_ext = {{2{in_b[WIDTH-1]}}, in_b};
    assign w_total = {{2{r_acc[WIDTH-1]}}, r_acc} + {{2{in_a[WIDTH-1]}}, in_a}
                   + (in_add ? w_b_ext : (~w_b_ext + {{(WIDTH+1){1'b0}}, 1'b1}));
    assign w_nacc  = w_beat_ovf ? (w_total[WIDTH+1] ? SMIN : SMAX) : w_nacc_raw;
`else
    assign w_r     = w_r_wrap;
    assign w_nacc  = w_nacc_raw;
`endif

    assign w_nacc_raw = r_acc + w_r;
    assign w_acc_ovf  = (r_acc[WIDTH-1] == w_r[WIDTH-1]) && (w_nacc_raw[WIDTH-1] != r_acc[WIDTH-1]);
    assign w_beat_ovf = w_op_ovf | w_acc_ovf;
    assign w_cnt_nxt  = (&r_cnt) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept)
            w_state_nxt = in_last ? S_OUT : S_ACC;
        else if (r_state == S_OUT && out_ready)
            w_state_nxt = S_IDLE;
    end

    always_comb begin
        in_ready  = (r_state != S_OUT) | out_ready;
        out_valid = (r_state == S_OUT);
        w_accept  = in_valid & in_ready;
    end

    // Internal acc/cnt/ovf are zero outside S_ACC, so a fresh packet uses the same update path.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_accept) begin
            if (in_last) begin
                r_out_sum   <= w_nacc;
                r_out_count <= w_cnt_nxt;
                r_out_ovf   <= r_ovf | w_beat_ovf;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_ovf       <= 1'b0;
            end else begin
                r_acc <= w_nacc;
                r_cnt <= w_cnt_nxt;
                r_ovf <= r_ovf | w_beat_ovf;
            end
        end
    end

    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule

// File: doc/addsub_accum.md
Name: addsub_accum

Overview:
- Sequential consumer stage directly downstream of the 36-bit add/subtract datapath.
- Accepts operand beats over a valid/ready handshake and computes a+b or a-b per beat with the same add/sub select polarity.
- Accumulates results across a packet delimited by in_last.
- Presents one registered packet total, beat count and signed-overflow flag to the next stage over a valid/ready handshake.

Parameters:
- WIDTH, 36, datapath width of operands, per-beat result and accumulator.
- CNT_W, 8, width of the beat counter.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  stage can accept a beat this cycle.
- in_a  input  WIDTH  first operand.
- in_b  input  WIDTH  second operand.
- in_add  input  1  1: r=a+b; 0: r=a-b (a+~b+1).
- in_last  input  1  beat closes the packet.
- out_valid  output  1  packet result held.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  accumulated packet total.
- out_count  output  CNT_W  beats in packet, including last.
- out_ovf  output  1  sticky signed overflow seen in packet.

Behaviour:
- Reset (clk edge with reset=1): state=S_IDLE, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0. Reset overrides every other event, including a mid-packet or held-output state; the partial packet is discarded.
- Beat accepted when in_valid & in_ready.
- Per-beat arithmetic: r = in_add ? a+b : a-b, modulo 2^WIDTH. Accumulate nacc = acc + r, modulo 2^WIDTH.
- Overflow uses two's-complement signed rules.
  - beat_ovf is set when the per-beat op overflows or the accumulate overflows.
  - Add overflows when operand signs are equal and the result sign differs.
  - Sub overflows when operand signs differ and the result sign differs from a.
- in_ready = (state != S_OUT) | out_ready. This is combinational from state and out_ready.
- States:
  - S_IDLE: acc=0, no beats.
    - Accepted beat with in_last=0 -> S_ACC; acc=r, cnt=1, ovf=beat_ovf.
    - Accepted beat with in_last=1 -> S_OUT; load outputs directly.
  - S_ACC: accepted beat updates acc=nacc, cnt=cnt+1 (saturating at 2^CNT_W-1), ovf|=beat_ovf.
    - in_last=1 -> S_OUT.
    - Output registers load from the updated values, out_valid=1, and internal acc/cnt/ovf clear to 0.
  - S_OUT: out_* held stable while out_valid & !out_ready.
    - out_ready=1 with no accepted beat -> S_IDLE, out_valid=0.
    - out_ready=1 with an accepted beat: the result is consumed and the beat starts a fresh packet in the same cycle (acc=r, cnt=1), with the same S_ACC/S_OUT rules.
    - Back-to-back single-beat packets (in_last=1) sustain one result per cycle.
- Latency: the last beat accepted at edge N gives out_valid=1 after edge N. Throughput is one beat per cycle when out_ready=1.
- out_sum, out_count and out_ovf change only on a load into S_OUT. They are not cleared on handshake and retain their last values when out_valid=0.
- in_a, in_b, in_add and in_last are ignored when no beat is accepted.

Optional Feature:
- Macro: ADDSUB_ACCUM_SAT_EN.
- Defined: on any beat_ovf, both r and nacc clamp to the signed extreme in the direction of the true result: 0x7FFFFFFFF for positive, 0x800000000 for negative. out_ovf behaves unchanged.
- Undefined: wrap modulo 2^WIDTH as above.

Test Plan:
- Reset then single beat a=5, b=3, in_add=1, in_last=1 -> next cycle out_valid=1, out_sum=8, out_count=1, out_ovf=0.
- Three beats (10+20, 7-9, 1-1, last on third), out_ready=1 -> out_sum=28, out_count=3. The next packet starts from acc=0.
- Sub: a=0, b=1 single beat -> out_sum=0xFFFFFFFFF, out_ovf=0.
- Add overflow: a=0x7FFFFFFFF, b=1, last -> out_ovf=1.
  - Without the macro: out_sum=0x800000000.
  - With ADDSUB_ACCUM_SAT_EN: out_sum=0x7FFFFFFFF.
- Backpressure: result held with out_ready=0 for 4 cycles -> in_ready=0 and outputs stable. Then out_ready=1 with in_valid=1 (2+2, last) -> old result consumed, new out_sum=4 on the next cycle, with no bubble.
- Two beats accepted, reset asserted, then a 1-beat packet 1+1 -> out_sum=2, out_count=1; the partial packet is discarded.
